oam_dma: RTL

OAM_DMA -- requirements
Module: oam_dma

---
 rtl/oam_dma_if.sv | 25 ++
 rtl/oam_dma.sv | 96 +++++++++
 2 files changed

// File: rtl/oam_dma_if.sv
// CPU-side bus, memory read port and OAM write port of the sprite DMA engine.
// The master modport is the system side; the slave modport is the DMA engine.
interface oam_dma_if;
  logic        ce;
  logic [15:0] cpu_a;
  logic [7:0]  cpu_o;
  logic        cpu_w;
  logic [7:0]  oam_base;
  logic [7:0]  prgi;
  logic        halt;
  logic [15:0] prga;
  logic [7:0]  oama;
  logic [7:0]  oamd;
  logic        oamw;

  modport master (
    output ce, cpu_a, cpu_o, cpu_w, oam_base, prgi,
    input  halt, prga, oama, oamd, oamw
  );

  modport slave (
    input  ce, cpu_a, cpu_o, cpu_w, oam_base, prgi,
    output halt, prga, oama, oamd, oamw
  );
endinterface

// File: rtl/oam_dma.sv
// Sprite DMA: a CPU write to $4014 copies a 256-byte page into OAM.
// The CPU is stalled for the transfer; odd-cycle triggers take one extra alignment cycle.
module oam_dma (
  input  logic      clock,
  input  logic      reset_n,
  oam_dma_if.slave  bus
);

  // state  | meaning
  // IDLE   | waiting for a write to $4014
  // ALIGN1 | extra dummy cycle taken when triggered on an odd CPU cycle
  // ALIGN2 | dummy cycle before the first read
  // READ   | present {page, idx} on prga
  // WRITE  | capture prgi and pulse oamw at base + idx
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ALIGN1 = 3'd1,
    ALIGN2 = 3'd2,
    READ   = 3'd3,
    WRITE  = 3'd4
  } state_t;

  state_t      state_q;
  logic        parity_q;
  logic [7:0]  page_q;
  logic [7:0]  base_q;
  logic [7:0]  idx_q;
  logic        halt_q;
  logic [15:0] prga_q;
  logic [7:0]  oama_q;
  logic [7:0]  oamd_q;
  logic        oamw_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      parity_q <= 1'b0;
      page_q   <= 8'h00;
      base_q   <= 8'h00;
      idx_q    <= 8'h00;
      halt_q   <= 1'b0;
      prga_q   <= 16'h0000;
      oama_q   <= 8'h00;
      oamd_q   <= 8'h00;
      oamw_q   <= 1'b0;
    end else begin
      // the write strobe is a single clock even when ce stays low afterwards
      oamw_q <= 1'b0;
      if (bus.ce) begin
        parity_q <= ~parity_q;
        case (state_q)
          IDLE: begin
            if (bus.cpu_w && (bus.cpu_a == 16'h4014)) begin
              page_q  <= bus.cpu_o;
              base_q  <= bus.oam_base;
              idx_q   <= 8'h00;
              halt_q  <= 1'b1;
              state_q <= parity_q ? ALIGN1 : ALIGN2;
            end
          end
          ALIGN1: state_q <= ALIGN2;
          ALIGN2: state_q <= READ;
          READ: begin
            prga_q  <= {page_q, idx_q};
            state_q <= WRITE;
          end
          WRITE: begin
            oamd_q <= bus.prgi;
            oama_q <= base_q + idx_q;
            oamw_q <= 1'b1;
            idx_q  <= idx_q + 8'd1;
            if (idx_q == 8'hFF) begin
              state_q <= IDLE;
              halt_q  <= 1'b0;
              prga_q  <= 16'h0000;
            end else begin
              state_q <= READ;
            end
          end
          default: begin
            state_q <= IDLE;
            halt_q  <= 1'b0;
            prga_q  <= 16'h0000;
          end
        endcase
      end
    end
  end

  assign bus.halt = halt_q;
  assign bus.prga = prga_q;
  assign bus.oama = oama_q;
  assign bus.oamd = oamd_q;
  assign bus.oamw = oamw_q;

endmodule
